// File: rtl/checker_pkg.sv
// Shared types and constants for the memory-write self-check harness.
package checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRun,
    StDone
  } state_e;

  localparam int unsigned     ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;
  localparam int unsigned     CYCLE_W = 32;

endpackage

// File: rtl/exp_table.sv
// Expected-write table: DEPTH entries of {address, data}, synchronous write,
// combinational read. Contents survive reset so a table can be reused across runs.
module exp_table #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ADDR_W-1:0]        wadr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ADDR_W-1:0]        radr_o,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W+DATA_W-1:0] mem_d [DEPTH];

  // Next table contents: one entry replaced when a load is accepted.
  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = {wadr_i, wdata_i};
    end
  end

  // Table storage, deliberately without reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign {radr_o, rdata_o} = mem_q[raddr_i];

endmodule

// File: rtl/memwrite_checker.sv
// Self-check harness: sequences the core reset, then compares the core's
// data-memory write stream against the expected-write table and reports a verdict.
module memwrite_checker
  import checker_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_idx,
  input  logic [ADDR_W-1:0]          load_adr,
  input  logic [DATA_W-1:0]          load_data,
  input  logic [$clog2(DEPTH+1)-1:0] num_exp,
  input  logic                       start,
  input  logic                       MemWrite,
  input  logic [ADDR_W-1:0]          DataAdr,
  input  logic [DATA_W-1:0]          WriteData,
  output logic                       core_reset,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [ERR_W-1:0]           err_count,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [CYCLE_W-1:0]         cycle_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   num_exp_q, num_exp_d;
  logic               core_reset_q, core_reset_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
  logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;

  logic              table_we;
  logic [ADDR_W-1:0] exp_adr;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;
  logic              finish;

  // Loads only land while the core is frozen, so a run never sees a half-updated table.
  assign table_we = load_en && ((state_q == StIdle) || (state_q == StDone));

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_exp_table (
    .clk_i   (clk),
    .we_i    (table_we),
    .waddr_i (load_idx),
    .wadr_i  (load_adr),
    .wdata_i (load_data),
    .raddr_i (idx_q[IDX_W-1:0]),
    .radr_o  (exp_adr),
    .rdata_o (exp_data)
  );

  // Next-state: run sequencing, write comparison, timeout and verdict.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    idx_d         = idx_q;
    num_exp_d     = num_exp_q;
    core_reset_d  = core_reset_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    err_count_d   = err_count_q;
    fail_idx_d    = fail_idx_q;
    cycle_count_d = cycle_count_q;
    mismatch      = 1'b0;
    finish        = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d       = StHold;
          hold_cnt_d    = '0;
          num_exp_d     = num_exp;
          idx_d         = '0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          timeout_d     = 1'b0;
          err_count_d   = '0;
          fail_idx_d    = '0;
          cycle_count_d = '0;
        end
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
          if (num_exp_q == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d      = StRun;
            core_reset_d = 1'b0;
          end
        end
      end
      StRun: begin
        cycle_count_d = cycle_count_q + 1'b1;
        if (MemWrite) begin
          mismatch = (DataAdr != exp_adr) || (WriteData != exp_data);
          idx_d    = idx_q + 1'b1;
          if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (err_count_q == '0) begin
              fail_idx_d = idx_q[IDX_W-1:0];
            end
          end
          finish = (idx_d == num_exp_q) || (mismatch && (STOP_ON_FAIL != 0));
        end
        // A completing write on the timeout cycle takes precedence.
        if (!finish && (cycle_count_d == CYCLE_W'(TIMEOUT))) begin
          finish    = 1'b1;
          timeout_d = 1'b1;
        end
        if (finish) begin
          state_d      = StDone;
          core_reset_d = 1'b1;
          done_d       = 1'b1;
          pass_d       = (err_count_d == '0) && !timeout_d;
          fail_d       = !pass_d;
        end
      end
      default: ;
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_cnt_q    <= '0;
      idx_q         <= '0;
      num_exp_q     <= '0;
      core_reset_q  <= 1'b1;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_count_q   <= '0;
      fail_idx_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      idx_q         <= idx_d;
      num_exp_q     <= num_exp_d;
      core_reset_q  <= core_reset_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      err_count_q   <= err_count_d;
      fail_idx_q    <= fail_idx_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign err_count   = err_count_q;
  assign fail_idx    = fail_idx_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// Bench for memwrite_checker: two instances (A: RESET_CYCLES=3, STOP_ON_FAIL=0;
// B: RESET_CYCLES=2, STOP_ON_FAIL=1; both TIMEOUT=16) share stimulus. A behavioural
// model is checked every cycle, plus hand-computed literal expectations.
module tb_memwrite_checker;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, load_en, start, mem_write;
  logic [3:0]  load_idx;
  logic [31:0] load_adr, load_data, data_adr, write_data;
  logic [4:0]  num_exp;

  logic        a_core_reset, a_done, a_pass, a_fail, a_timeout;
  logic [7:0]  a_err;
  logic [3:0]  a_fidx;
  logic [31:0] a_cyc;
  logic        b_core_reset, b_done, b_pass, b_fail, b_timeout;
  logic [7:0]  b_err;
  logic [3:0]  b_fidx;
  logic [31:0] b_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memwrite_checker #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .RESET_CYCLES(3), .TIMEOUT(TO), .STOP_ON_FAIL(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_adr(load_adr),
    .load_data(load_data), .num_exp(num_exp), .start(start), .MemWrite(mem_write),
    .DataAdr(data_adr), .WriteData(write_data), .core_reset(a_core_reset), .done(a_done),
    .pass(a_pass), .fail(a_fail), .timeout(a_timeout), .err_count(a_err), .fail_idx(a_fidx),
    .cycle_count(a_cyc)
  );

  memwrite_checker #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .RESET_CYCLES(2), .TIMEOUT(TO), .STOP_ON_FAIL(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx), .load_adr(load_adr),
    .load_data(load_data), .num_exp(num_exp), .start(start), .MemWrite(mem_write),
    .DataAdr(data_adr), .WriteData(write_data), .core_reset(b_core_reset), .done(b_done),
    .pass(b_pass), .fail(b_fail), .timeout(b_timeout), .err_count(b_err), .fail_idx(b_fidx),
    .cycle_count(b_cyc)
  );

  // ---------------- behavioural model ----------------
  int          m_rc[2]  = '{3, 2};
  bit          m_sof[2] = '{1'b0, 1'b1};
  int          m_phase[2];  // 0 idle, 1 hold, 2 run, 3 done
  int          m_hold_left[2], m_nexp[2], m_idx[2], m_errs[2], m_ffail[2], m_cycles[2];
  bit          m_done[2], m_pass[2], m_fail[2], m_tmo[2];
  logic [63:0] m_tbl[2][16];
  bit          m_valid = 1'b0;

  task automatic model_step(input int i);
    bit fin;
    bit hit;
    if (reset) begin
      m_phase[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0;
      m_errs[i] = 0; m_ffail[i] = 0; m_cycles[i] = 0; m_idx[i] = 0;
    end else begin
      case (m_phase[i])
        0, 3: begin
          if (load_en) m_tbl[i][load_idx] = {load_adr, load_data};
          if (start) begin
            m_phase[i] = 1; m_hold_left[i] = m_rc[i]; m_nexp[i] = int'(num_exp);
            m_idx[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_tmo[i] = 0;
            m_errs[i] = 0; m_ffail[i] = 0; m_cycles[i] = 0;
          end
        end
        1: begin
          m_hold_left[i]--;
          if (m_hold_left[i] == 0) begin
            if (m_nexp[i] == 0) begin
              m_phase[i] = 3; m_done[i] = 1; m_pass[i] = 1;
            end else begin
              m_phase[i] = 2;
            end
          end
        end
        2: begin
          fin = 0;
          m_cycles[i]++;
          if (mem_write) begin
            hit = (m_tbl[i][m_idx[i]] === {data_adr, write_data});
            if (!hit) begin
              if (m_errs[i] == 0) m_ffail[i] = m_idx[i];
              if (m_errs[i] < 255) m_errs[i]++;
            end
            m_idx[i]++;
            if (m_idx[i] == m_nexp[i] || (!hit && m_sof[i])) fin = 1;
          end
          if (!fin && m_cycles[i] == TO) begin
            fin = 1; m_tmo[i] = 1;
          end
          if (fin) begin
            m_phase[i] = 3; m_done[i] = 1;
            m_pass[i] = (m_errs[i] == 0) && !m_tmo[i];
            m_fail[i] = !m_pass[i];
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    if (reset) m_valid = 1'b1;
  end

  function automatic logic [48:0] exp_vec(input int i);
    return {m_phase[i] != 2, m_done[i], m_pass[i], m_fail[i], m_tmo[i],
            8'(m_errs[i]), 4'(m_ffail[i]), 32'(m_cycles[i])};
  endfunction

  function automatic logic [48:0] act_vec(input int i);
    if (i == 0) return {a_core_reset, a_done, a_pass, a_fail, a_timeout, a_err, a_fidx, a_cyc};
    return {b_core_reset, b_done, b_pass, b_fail, b_timeout, b_err, b_fidx, b_cyc};
  endfunction

  // Every-cycle compare against the model, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          n_fail++;
          $display("FAIL model_cmp inst=%0d t=%0t got=%h want=%h", i, $time, act_vec(i),
                   exp_vec(i));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [31:0] adr, input logic [31:0] data);
    load_en = 1'b1; load_idx = 4'(idx); load_adr = adr; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_exp = 5'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] data);
    mem_write = 1'b1; data_adr = adr; write_data = data;
    tick();
    mem_write = 1'b0;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; start = 1'b0; mem_write = 1'b0; load_idx = '0;
    load_adr = '0; load_data = '0; data_adr = '0; write_data = '0; num_exp = '0;
    tick(); tick();
    chk("rst_core_reset", 32'(a_core_reset), 1);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_cycle_count", a_cyc, 0);
    reset = 1'b0;

    // Pass run, writes with gaps; a stray start mid-run must be ignored.
    load(0, 32'h64, 32'd7); load(1, 32'h68, 32'd10); load(2, 32'h64, 32'd7);
    do_start(3);
    tick(); tick();
    chk("hold_core_reset", 32'(a_core_reset), 1);
    tick();
    chk("run_core_reset", 32'(a_core_reset), 0);
    wr(32'h64, 32'd7);
    num_exp = 5'd0; start = 1'b1; tick(); start = 1'b0;
    wr(32'h68, 32'd10);
    chk("pass_not_done_early", 32'(a_done), 0);
    tick();
    wr(32'h64, 32'd7);
    chk("pass_done", 32'(a_done), 1);
    chk("pass_pass", 32'(a_pass), 1);
    chk("pass_err", 32'(a_err), 0);
    chk("pass_core_reset", 32'(a_core_reset), 1);
    chk("pass_cycles_a", a_cyc, 5);
    chk("pass_cycles_b", b_cyc, 6);

    // Error counting without stopping (A); B stops on the same mismatch.
    do_start(3); tick(); tick(); tick();
    wr(32'h64, 32'd7); tick();
    wr(32'h68, 32'hB);
    chk("err_a_running", 32'(a_done), 0);
    chk("err_b_stopped", 32'(b_done), 1);
    chk("err_b_fidx", 32'(b_fidx), 1);
    tick();
    wr(32'h64, 32'd7);
    chk("err_a_done", 32'(a_done), 1);
    chk("err_a_fail", 32'(a_fail), 1);
    chk("err_a_count", 32'(a_err), 1);
    chk("err_a_fidx", 32'(a_fidx), 1);

    // Stop on first-write address mismatch (B); later writes ignored.
    do_start(3); tick(); tick(); tick();
    wr(32'h60, 32'd7);
    chk("sof_b_done", 32'(b_done), 1);
    chk("sof_b_fail", 32'(b_fail), 1);
    chk("sof_b_fidx", 32'(b_fidx), 0);
    chk("sof_a_running", 32'(a_done), 0);
    tick(); wr(32'h68, 32'd10); tick(); wr(32'h64, 32'd7);
    chk("sof_b_err_held", 32'(b_err), 1);
    chk("sof_a_fidx", 32'(a_fidx), 0);

    // Timeout with no writes.
    do_start(3);
    repeat (18) tick();
    chk("tmo_a_not_yet", 32'(a_done), 0);
    chk("tmo_b_timeout", 32'(b_timeout), 1);
    tick();
    chk("tmo_a_done", 32'(a_done), 1);
    chk("tmo_a_timeout", 32'(a_timeout), 1);
    chk("tmo_a_fail", 32'(a_fail), 1);
    chk("tmo_a_cycles", a_cyc, 16);

    // Final write on the timeout cycle; entry loaded in the same cycle as start.
    load_en = 1'b1; load_idx = 4'd0; load_adr = 32'h70; load_data = 32'd5;
    do_start(1);
    load_en = 1'b0;
    repeat (18) tick();
    wr(32'h70, 32'd5);
    chk("tie_a_pass", 32'(a_pass), 1);
    chk("tie_a_timeout", 32'(a_timeout), 0);
    chk("tie_a_cycles", a_cyc, 16);

    // Zero-length run.
    load(0, 32'h64, 32'd7);
    do_start(0); tick();
    tick();
    chk("zero_a_not_yet", 32'(a_done), 0);
    chk("zero_b_done", 32'(b_done), 1);
    tick();
    chk("zero_a_done", 32'(a_done), 1);
    chk("zero_a_pass", 32'(a_pass), 1);

    // Reset mid-run (a load attempted in RUN must be dropped), then reuse the table.
    do_start(3); tick(); tick(); tick();
    wr(32'h64, 32'd7);
    load(1, 32'hDEAD, 32'hBEEF);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_core_reset", 32'(a_core_reset), 1);
    chk("mid_rst_cycles", a_cyc, 0);
    chk("mid_rst_done", 32'(a_done), 0);
    do_start(3); tick(); tick(); tick();
    wr(32'h64, 32'd7); wr(32'h68, 32'd10); wr(32'h64, 32'd7);
    chk("retain_a_pass", 32'(a_pass), 1);
    chk("retain_b_pass", 32'(b_pass), 1);
    chk("retain_a_cycles", a_cyc, 3);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
